citadel_io_bridge: RTL and testbench

//  Host-side endpoint for the SoC byte-IO link (tx/tx_ready out of the SoC; rx/rx_ready in, rx_ack back).

---
 rtl/citadel_io_bridge_if.sv | 54 +++++
 rtl/citadel_io_bridge.sv | 264 ++++++++++++++++++++++++++
 tb/tb_citadel_io_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/citadel_io_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : citadel_io_bridge_if
//  Description : Bundle of the SoC byte-IO link and the host byte streams
//                serviced by citadel_io_bridge. The slave modport is the
//                bridge's view; the master modport is the SoC/host side.
//  Revision    : 1.0  initial release
// ============================================================================
interface citadel_io_bridge_if #(
    parameter int UP_DEPTH   = 16,
    parameter int DOWN_DEPTH = 16
);
    localparam int c_UP_LW   = $clog2(UP_DEPTH) + 1;
    localparam int c_DOWN_LW = $clog2(DOWN_DEPTH) + 1;

    // SoC byte-IO link
    logic [7:0]           soc_tx;
    logic                 soc_tx_ready;
    logic [7:0]           soc_rx;
    logic                 soc_rx_ready;
    logic                 soc_rx_ack;

    // Host stream towards the host (SoC -> host)
    logic [7:0]           host_out_data;
    logic                 host_out_valid;
    logic                 host_out_ready;

    // Host stream towards the SoC (host -> SoC)
    logic [7:0]           host_in_data;
    logic                 host_in_valid;
    logic                 host_in_ready;

    // Status
    logic                 up_overflow;
    logic [c_UP_LW-1:0]   up_level;
    logic [c_DOWN_LW-1:0] down_level;

    modport slave (
        input  soc_tx, soc_tx_ready, soc_rx_ack,
        input  host_out_ready, host_in_data, host_in_valid,
        output soc_rx, soc_rx_ready,
        output host_out_data, host_out_valid, host_in_ready,
        output up_overflow, up_level, down_level
    );

    modport master (
        output soc_tx, soc_tx_ready, soc_rx_ack,
        output host_out_ready, host_in_data, host_in_valid,
        input  soc_rx, soc_rx_ready,
        input  host_out_data, host_out_valid, host_in_ready,
        input  up_overflow, up_level, down_level
    );
endinterface
`default_nettype wire

// File: rtl/citadel_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : citadel_io_bridge
//  Description : Host-side endpoint of the SoC byte-IO link. SoC tx bytes are
//                captured on rising strobe edges into an "up" FIFO drained by
//                a first-word-fall-through host port. Host bytes are queued in
//                a "down" FIFO and presented one at a time on soc_rx /
//                soc_rx_ready until the SoC acknowledges with a rising ack.
//  Options     : CITADEL_IO_LOOPBACK_EN - adds a `loopback` input that routes
//                the up FIFO straight into the down FIFO and fences off the
//                host ports while asserted.
//  Revision    : 1.0  initial release
// ============================================================================
module citadel_io_bridge #(
    parameter int UP_DEPTH   = 16,
    parameter int DOWN_DEPTH = 16
) (
    input  logic r_clk,
    input  logic rst,
`ifdef CITADEL_IO_LOOPBACK_EN
    input  logic loopback,
`endif
    citadel_io_bridge_if.slave bus
);

    localparam int c_UAW = $clog2(UP_DEPTH);
    localparam int c_DAW = $clog2(DOWN_DEPTH);

    localparam logic [c_UAW:0] c_UP_FULL   = (c_UAW+1)'(UP_DEPTH);
    localparam logic [c_DAW:0] c_DOWN_FULL = (c_DAW+1)'(DOWN_DEPTH);

    // Presenter state encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PRESENT = 2'd1;
    localparam logic [1:0] c_ST_GAP     = 2'd2;

    // ------------------------------------------------------------------------
    //  Loopback select (constant zero when the option is not built)
    // ------------------------------------------------------------------------
    logic w_loopback;
`ifdef CITADEL_IO_LOOPBACK_EN
    assign w_loopback = loopback;
`else
    assign w_loopback = 1'b0;
`endif

    // ------------------------------------------------------------------------
    //  Strobe edge detection
    // ------------------------------------------------------------------------
    logic r_tx_q;
    logic r_ack_q;
    logic r_rst_q;
    logic w_tx_evt;
    logic w_ack_evt;

    // Previous-cycle copies of the SoC strobes and of reset for edge detection
    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_tx_q  <= 1'b0;
            r_ack_q <= 1'b0;
            r_rst_q <= 1'b1;
        end else begin
            r_tx_q  <= bus.soc_tx_ready;
            r_ack_q <= bus.soc_rx_ack;
            r_rst_q <= 1'b0;
        end
    end

    // The cycle straight after reset is masked so that a strobe held high
    // across reset is seen as an old level, not a fresh edge.
    assign w_tx_evt  = bus.soc_tx_ready & ~r_tx_q  & ~r_rst_q;
    assign w_ack_evt = bus.soc_rx_ack   & ~r_ack_q & ~r_rst_q;

    // ------------------------------------------------------------------------
    //  Up FIFO (SoC -> host)
    // ------------------------------------------------------------------------
    logic [7:0]       r_up_mem [UP_DEPTH];
    logic [c_UAW-1:0] r_up_wptr;
    logic [c_UAW-1:0] r_up_rptr;
    logic [c_UAW:0]   r_up_cnt;
    logic             r_up_ovf;
    logic             w_up_empty;
    logic             w_up_full;
    logic             w_up_push;
    logic             w_up_pop;
    logic             w_up_drop;
    logic [7:0]       w_up_head;

    // ------------------------------------------------------------------------
    //  Down FIFO (host -> SoC)
    // ------------------------------------------------------------------------
    logic [7:0]       r_down_mem [DOWN_DEPTH];
    logic [c_DAW-1:0] r_down_wptr;
    logic [c_DAW-1:0] r_down_rptr;
    logic [c_DAW:0]   r_down_cnt;
    logic             w_down_empty;
    logic             w_down_full;
    logic             w_down_push;
    logic             w_down_pop;
    logic [7:0]       w_down_wdata;

    logic             w_lb_move;
    logic             w_host_in_ready;

    assign w_up_empty   = (r_up_cnt == '0);
    assign w_up_full    = (r_up_cnt == c_UP_FULL);
    assign w_up_head    = r_up_mem[r_up_rptr];

    assign w_down_empty = (r_down_cnt == '0);
    assign w_down_full  = (r_down_cnt == c_DOWN_FULL);

    // Loopback moves one byte per cycle from the up head into the down tail
    assign w_lb_move = w_loopback & ~w_up_empty & ~w_down_full & ~r_rst_q;

    // Host pop or loopback transfer both retire the up FIFO head
    assign w_up_pop  = w_loopback ? w_lb_move
                                  : (~w_up_empty & bus.host_out_ready);

    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign w_up_push = w_tx_evt & (~w_up_full | w_up_pop);
    assign w_up_drop = w_tx_evt &  w_up_full  & ~w_up_pop;

    // No full-cycle bypass: ready depends only on registered occupancy
    assign w_host_in_ready = ~r_rst_q & ~w_down_full & ~w_loopback;

    assign w_down_push  = w_loopback ? w_lb_move
                                     : (bus.host_in_valid & w_host_in_ready);
    assign w_down_wdata = w_loopback ? w_up_head : bus.host_in_data;

    // Up FIFO storage; contents need no reset since the count gates reads
    always_ff @(posedge r_clk) begin
        if (w_up_push) begin
            r_up_mem[r_up_wptr] <= bus.soc_tx;
        end
    end

    // Up FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_up_wptr <= '0;
            r_up_rptr <= '0;
            r_up_cnt  <= '0;
            r_up_ovf  <= 1'b0;
        end else begin
            if (w_up_push) begin
                r_up_wptr <= r_up_wptr + 1'b1;
            end
            if (w_up_pop) begin
                r_up_rptr <= r_up_rptr + 1'b1;
            end
            case ({w_up_push, w_up_pop})
                2'b10:   r_up_cnt <= r_up_cnt + 1'b1;
                2'b01:   r_up_cnt <= r_up_cnt - 1'b1;
                default: r_up_cnt <= r_up_cnt;
            endcase
            if (w_up_drop) begin
                r_up_ovf <= 1'b1;
            end
        end
    end

    // Down FIFO storage
    always_ff @(posedge r_clk) begin
        if (w_down_push) begin
            r_down_mem[r_down_wptr] <= w_down_wdata;
        end
    end

    // Down FIFO pointers and occupancy
    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_down_wptr <= '0;
            r_down_rptr <= '0;
            r_down_cnt  <= '0;
        end else begin
            if (w_down_push) begin
                r_down_wptr <= r_down_wptr + 1'b1;
            end
            if (w_down_pop) begin
                r_down_rptr <= r_down_rptr + 1'b1;
            end
            case ({w_down_push, w_down_pop})
                2'b10:   r_down_cnt <= r_down_cnt + 1'b1;
                2'b01:   r_down_cnt <= r_down_cnt - 1'b1;
                default: r_down_cnt <= r_down_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    //  Presenter FSM
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_rx_ready;
    logic [7:0] r_soc_rx;

    // State register
    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: present a byte, wait for the ack edge, then idle one
    // cycle with ready low so the SoC sees a fresh access for the next byte
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_down_empty) begin
                    w_state_nxt = c_ST_PRESENT;
                end
            end
            c_ST_PRESENT: begin
                if (w_ack_evt) begin
                    w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode: pop the down head on leaving IDLE, assert ready in PRESENT
    always_comb begin
        w_down_pop = 1'b0;
        w_rx_ready = 1'b0;
        case (r_state)
            c_ST_IDLE:    w_down_pop = ~w_down_empty;
            c_ST_PRESENT: w_rx_ready = 1'b1;
            default:      ;
        endcase
    end

    // Presented byte register; keeps the last byte after the ack
    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_soc_rx <= 8'h00;
        end else if (w_down_pop) begin
            r_soc_rx <= r_down_mem[r_down_rptr];
        end
    end

    // ------------------------------------------------------------------------
    //  Outputs
    // ------------------------------------------------------------------------
    assign bus.soc_rx         = r_soc_rx;
    assign bus.soc_rx_ready   = w_rx_ready;
    assign bus.host_out_data  = w_up_empty ? 8'h00 : w_up_head;
    assign bus.host_out_valid = ~w_up_empty & ~w_loopback;
    assign bus.host_in_ready  = w_host_in_ready;
    assign bus.up_overflow    = r_up_ovf;
    assign bus.up_level       = r_up_cnt;
    assign bus.down_level     = r_down_cnt;

endmodule
`default_nettype wire

// File: tb/tb_citadel_io_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_citadel_io_bridge
//  Description : Directed self-checking bench for citadel_io_bridge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_citadel_io_bridge;

    localparam int UP_DEPTH   = 16;
    localparam int DOWN_DEPTH = 16;

    logic r_clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    citadel_io_bridge_if #(.UP_DEPTH(UP_DEPTH), .DOWN_DEPTH(DOWN_DEPTH)) bus ();

`ifdef CITADEL_IO_LOOPBACK_EN
    logic loopback;
`endif

    citadel_io_bridge #(
        .UP_DEPTH   (UP_DEPTH),
        .DOWN_DEPTH (DOWN_DEPTH)
    ) dut (
        .r_clk    (r_clk),
        .rst      (rst),
`ifdef CITADEL_IO_LOOPBACK_EN
        .loopback (loopback),
`endif
        .bus      (bus)
    );

    always #5 r_clk = ~r_clk;

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_b;

        bus.soc_tx         = 8'h99;
        bus.soc_tx_ready   = 1'b1;     // held high across reset
        bus.soc_rx_ack     = 1'b0;
        bus.host_out_ready = 1'b0;
        bus.host_in_data   = 8'h00;
        bus.host_in_valid  = 1'b0;
`ifdef CITADEL_IO_LOOPBACK_EN
        loopback = 1'b0;
`endif
        rst = 1'b1;

        // T1: two reset cycles, all outputs low
        tick();
        tick();
        check("rst_host_out_valid", bus.host_out_valid, 0);
        check("rst_host_out_data",  bus.host_out_data,  0);
        check("rst_host_in_ready",  bus.host_in_ready,  0);
        check("rst_soc_rx_ready",   bus.soc_rx_ready,   0);
        check("rst_soc_rx",         bus.soc_rx,         0);
        check("rst_up_overflow",    bus.up_overflow,    0);
        check("rst_up_level",       bus.up_level,       0);
        check("rst_down_level",     bus.down_level,     0);

        rst = 1'b0;
        tick();
        check("post_rst_host_in_ready", bus.host_in_ready, 1);
        check("held_strobe_no_event_a", bus.up_level, 0);
        tick();
        check("held_strobe_no_event_b", bus.up_level, 0);
        bus.soc_tx_ready = 1'b0;
        tick();

        // T2: single byte, 3-cycle strobe, host ready
        bus.host_out_ready = 1'b1;
        bus.soc_tx         = 8'h41;
        bus.soc_tx_ready   = 1'b1;
        tick();
        check("t2_valid",     bus.host_out_valid, 1);
        check("t2_data",      bus.host_out_data,  8'h41);
        check("t2_level_one", bus.up_level,       1);
        tick();
        check("t2_level_zero", bus.up_level,       0);
        check("t2_valid_gone", bus.host_out_valid, 0);
        tick();
        check("t2_no_second_byte", bus.up_level, 0);
        bus.soc_tx_ready = 1'b0;
        tick();

        // T3: fill the up FIFO, overflow on the 17th, full+pop accepted
        bus.host_out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.soc_tx       = 8'(8'h80 + k);
            bus.soc_tx_ready = 1'b1;
            tick();
            bus.soc_tx_ready = 1'b0;
            tick();
        end
        check("t3_full_level",   bus.up_level,      16);
        check("t3_no_ovf_yet",   bus.up_overflow,   0);
        check("t3_head_stable",  bus.host_out_data, 8'h80);

        bus.soc_tx       = 8'h90;
        bus.soc_tx_ready = 1'b1;
        tick();
        bus.soc_tx_ready = 1'b0;
        tick();
        check("t3_overflow",      bus.up_overflow, 1);
        check("t3_level_at_full", bus.up_level,    16);

        bus.soc_tx         = 8'h91;
        bus.soc_tx_ready   = 1'b1;
        bus.host_out_ready = 1'b1;
        tick();
        bus.host_out_ready = 1'b0;
        bus.soc_tx_ready   = 1'b0;
        tick();
        check("t3_full_pop_level", bus.up_level,      16);
        check("t3_full_pop_head",  bus.host_out_data, 8'h81);

        bus.host_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(8'h81 + i) : 8'h91;
            check($sformatf("t3_drain_%0d", i), bus.host_out_data, exp_b);
            tick();
        end
        bus.host_out_ready = 1'b0;
        check("t3_empty_level",  bus.up_level,       0);
        check("t3_empty_valid",  bus.host_out_valid, 0);
        check("t3_ovf_sticky",   bus.up_overflow,    1);

        // T4: two host bytes presented in turn with ack handshakes
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 8'h10;
        tick();
        check("t4_not_yet_ready", bus.soc_rx_ready, 0);
        check("t4_down_level_1",  bus.down_level,   1);
        bus.host_in_data  = 8'h20;
        tick();
        bus.host_in_valid = 1'b0;
        check("t4_rx_first",      bus.soc_rx,       8'h10);
        check("t4_ready_first",   bus.soc_rx_ready, 1);
        check("t4_down_level_b",  bus.down_level,   1);
        tick();
        tick();
        check("t4_hold_ready",    bus.soc_rx_ready, 1);
        check("t4_hold_rx",       bus.soc_rx,       8'h10);
        bus.soc_rx_ack = 1'b1;
        tick();
        check("t4_gap_ready",     bus.soc_rx_ready, 0);
        check("t4_rx_retained",   bus.soc_rx,       8'h10);
        bus.soc_rx_ack = 1'b0;
        tick();
        check("t4_idle_ready",    bus.soc_rx_ready, 0);
        check("t4_queued_level",  bus.down_level,   1);
        // Rising ack while in IDLE must not retire the byte presented now
        bus.soc_rx_ack = 1'b1;
        tick();
        check("t4_rx_second",     bus.soc_rx,       8'h20);
        check("t4_ready_second",  bus.soc_rx_ready, 1);
        check("t4_down_empty",    bus.down_level,   0);
        tick();
        check("t5_idle_ack_ignored", bus.soc_rx_ready, 1);
        bus.soc_rx_ack = 1'b0;
        tick();
        bus.soc_rx_ack = 1'b1;
        tick();
        check("t4_second_acked",  bus.soc_rx_ready, 0);
        bus.soc_rx_ack = 1'b0;
        tick();

        // T5: ack pulse with nothing presented
        bus.soc_rx_ack = 1'b1;
        tick();
        bus.soc_rx_ack = 1'b0;
        tick();
        check("t5_ready_low",     bus.soc_rx_ready, 0);
        check("t5_level_same",    bus.down_level,   0);
        check("t5_rx_kept",       bus.soc_rx,       8'h20);

        // Reset in the middle of a transfer
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 8'h33;
        tick();
        bus.host_in_data  = 8'h44;
        tick();
        bus.host_in_valid = 1'b0;
        check("mid_rx",           bus.soc_rx,       8'h33);
        check("mid_level",        bus.down_level,   1);
        rst = 1'b1;
        tick();
        check("mid_rst_ready",    bus.soc_rx_ready,  0);
        check("mid_rst_level",    bus.down_level,    0);
        check("mid_rst_in_ready", bus.host_in_ready, 0);
        check("mid_rst_rx",       bus.soc_rx,        0);
        rst = 1'b0;
        tick();
        check("mid_in_ready_back", bus.host_in_ready, 1);
        tick();
        check("mid_nothing_presented", bus.soc_rx_ready, 0);

`ifdef CITADEL_IO_LOOPBACK_EN
        // T6: loopback routes the SoC byte back to the SoC rx side
        loopback = 1'b1;
        tick();
        check("t6_in_ready_forced", bus.host_in_ready, 0);
        bus.soc_tx       = 8'h55;
        bus.soc_tx_ready = 1'b1;
        tick();
        bus.soc_tx_ready = 1'b0;
        check("t6_out_valid_forced", bus.host_out_valid, 0);
        check("t6_up_level",         bus.up_level,       1);
        tick();
        check("t6_moved_up",         bus.up_level,       0);
        check("t6_moved_down",       bus.down_level,     1);
        tick();
        check("t6_rx",               bus.soc_rx,         8'h55);
        check("t6_rx_ready",         bus.soc_rx_ready,   1);
        check("t6_out_valid_still",  bus.host_out_valid, 0);
        loopback = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
